// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared fetch-stage types and constants
package core_pkg;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

    localparam logic [31:0] WORD_BYTES       = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - in-order {pc, instr} FIFO with single-cycle flush
module fetch_buf
    import core_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  fetch_entry_t                 i_push_data,
    input  logic                         i_pop,
    output fetch_entry_t                 o_head,
    output logic                         o_valid,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t   r_mem [DEPTH];
    logic [AW-1:0]  r_rd_ptr;
    logic [AW-1:0]  r_wr_ptr;
    logic [CW-1:0]  r_count;

    // Explicit wrap so non-power-of-two depths index correctly
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - credit-limited instruction fetch with redirect discard and halt drain
module fetch_sequencer
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        halted
);

    localparam int CW = $clog2(BUF_DEPTH + 1);

    fetch_state_t   r_state;
    logic [31:0]    r_pc;
    logic [31:0]    r_resp_pc;
    logic [CW-1:0]  r_outst;
    logic [CW-1:0]  r_discard;

    logic           w_fire;
    logic           w_drop;
    logic           w_push;
    logic           w_pop;
    logic           w_credit;
    logic           w_buf_valid;
    logic [CW-1:0]  w_buf_count;
    logic [CW-1:0]  w_outst_next;
    fetch_entry_t   w_head;
    fetch_entry_t   w_push_data;

    // r_outst counts every in-flight request, discarded ones included,
    // so the credit check also covers responses still owed after a redirect
    assign w_credit = ({1'b0, w_buf_count} + {1'b0, r_outst}) < (CW+1)'(BUF_DEPTH);
    assign imem_req  = !rst && (r_state == ST_FETCH) && !halt && w_credit;
    assign imem_addr = rst ? '0 : r_pc;

    assign w_fire       = imem_req && imem_gnt;
    assign w_drop       = imem_rvalid && (r_discard != '0);
    assign w_push       = imem_rvalid && !w_drop && !redirect_valid;
    assign w_pop        = w_buf_valid && out_ready && !redirect_valid;
    assign w_outst_next = r_outst + CW'(w_fire) - CW'(imem_rvalid);
    assign w_push_data  = '{pc: r_resp_pc, instr: imem_rdata};

    // Responses are in order, so the next kept response always belongs to r_resp_pc
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_pc      <= RESET_PC;
            r_resp_pc <= RESET_PC;
            r_outst   <= '0;
            r_discard <= '0;
        end else begin
            r_outst <= w_outst_next;
            if (redirect_valid) begin
                r_pc      <= redirect_pc & ~32'h3;
                r_resp_pc <= redirect_pc & ~32'h3;
                r_discard <= w_outst_next;
            end else begin
                if (w_fire) r_pc      <= r_pc + WORD_BYTES;
                if (w_push) r_resp_pc <= r_resp_pc + WORD_BYTES;
                if (w_drop) r_discard <= r_discard - 1'b1;
            end
            case (r_state)
                ST_FETCH:  if (halt) r_state <= ST_DRAIN;
                ST_DRAIN: begin
                    if (!halt)                    r_state <= ST_FETCH;
                    else if (w_outst_next == '0)  r_state <= ST_HALTED;
                end
                ST_HALTED: if (!halt) r_state <= ST_FETCH;
                default:   r_state <= ST_FETCH;
            endcase
        end
    end

    fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (redirect_valid),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_valid     (w_buf_valid),
        .o_count     (w_buf_count)
    );

    assign out_valid = w_buf_valid;
    assign out_pc    = w_buf_valid ? w_head.pc    : '0;
    assign out_instr = w_buf_valid ? w_head.instr : '0;
    assign halted    = (r_state == ST_HALTED);

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;
    import core_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, imem_gnt, imem_rvalid, redirect_valid, halt, out_ready;
    logic [31:0] imem_rdata, redirect_pc;
    logic        imem_req, out_valid, halted;
    logic [31:0] imem_addr, out_pc, out_instr;
    logic        d2_req, d2_out_valid, d2_halted;
    logic [31:0] d2_addr, d2_out_pc, d2_out_instr;

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .halted(halted)
    );

    fetch_sequencer #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst(rst), .imem_req(d2_req), .imem_addr(d2_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .out_valid(d2_out_valid), .out_ready(out_ready), .out_pc(d2_out_pc),
        .out_instr(d2_out_instr), .halted(d2_halted)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] q_mem[$];
    logic [63:0] exp_q[$];
    logic [31:0] pops1[$];
    logic [31:0] pops2[$];
    logic [31:0] gnt_log[$];
    int          drop_n = 0;
    bit          mem_en = 1'b1;
    bit          cap = 1'b0;
    int          cyc = 0;
    int          n_req = 0;
    int          n_pop = 0;
    int          first_req_cyc = -1;
    int          first_ov_cyc = -1;
    logic [31:0] rsp_addr = '0;
    logic [31:0] last_gnt_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_5A5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    // One clock: observe at negedge, then drive memory response after the edge
    task automatic tick(input int n);
        logic [63:0] e;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("buf_overflow", 32'(dut.u_buf.r_count <= 2), 32'd1);
            if (!rst) begin
                if (imem_req && first_req_cyc < 0) first_req_cyc = cyc;
                if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
                if (out_valid && out_ready && !redirect_valid) begin
                    chk("exp_avail", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("out_pc", out_pc, e[63:32]);
                        chk("out_instr", out_instr, e[31:0]);
                    end
                    n_pop++;
                    if (cap) pops1.push_back(out_pc);
                end
                if (d2_out_valid && out_ready && !redirect_valid && cap) pops2.push_back(d2_out_pc);
                if (imem_rvalid && !redirect_valid) begin
                    if (drop_n > 0) drop_n--;
                    else exp_q.push_back({rsp_addr, imem_rdata});
                end
                if (imem_req && imem_gnt) begin
                    q_mem.push_back(imem_addr);
                    n_req++;
                    last_gnt_addr = imem_addr;
                    if (cap) gnt_log.push_back(imem_addr);
                end
                if (redirect_valid) begin
                    exp_q.delete();
                    drop_n = q_mem.size();
                end
            end
            @(posedge clk);
            #1;
            cyc++;
            if (mem_en && !rst && q_mem.size() > 0) begin
                rsp_addr    = q_mem.pop_front();
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(rsp_addr);
            end else begin
                imem_rvalid = 1'b0;
            end
        end
    endtask

    initial begin
        int base, pbase;
        logic [31:0] hold_addr, nexp;
        rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; out_ready = 1'b0;
        tick(2);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);

        // Zero-wait streaming from both reset vectors
        imem_gnt = 1'b1; out_ready = 1'b1; cap = 1'b1; cyc = 0; rst = 1'b0;
        tick(12);
        cap = 1'b0;
        chk("ov_latency", 32'(first_ov_cyc - first_req_cyc), 32'd2);
        chk("seq0", at(pops1, 0), 32'h0);
        chk("seq1", at(pops1, 1), 32'h4);
        chk("seq2", at(pops1, 2), 32'h8);
        chk("seq3", at(pops1, 3), 32'hC);
        chk("wrap0", at(pops2, 0), 32'hFFFF_FFF8);
        chk("wrap1", at(pops2, 1), 32'hFFFF_FFFC);
        chk("wrap2", at(pops2, 2), 32'h0000_0000);
        halt = 1'b1;
        for (int i = 0; i < 20 && !halted; i++) tick(1);
        chk("halted_t1", 32'(halted), 32'd1);
        tick(3);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_ov", 32'(out_valid), 32'd0);

        // Credit limit with decode stalled
        out_ready = 1'b0; halt = 1'b0; base = n_req;
        tick(8);
        chk("credit_reqs", 32'(n_req - base), 32'd2);
        chk("credit_req_low", 32'(imem_req), 32'd0);
        chk("buf_full", 32'(dut.u_buf.r_count), 32'd2);
        chk("full_ov", 32'(out_valid), 32'd1);
        out_ready = 1'b1; pbase = n_pop;
        tick(1);
        out_ready = 1'b0;
        tick(4);
        chk("one_pop", 32'(n_pop - pbase), 32'd1);
        chk("one_more_req", 32'(n_req - base), 32'd3);

        // Redirect with two requests in flight
        out_ready = 1'b1; mem_en = 1'b0;
        tick(4);
        chk("outst_before_redir", 32'(q_mem.size()), 32'd2);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_1003;
        tick(1);
        redirect_valid = 1'b0;
        chk("ov_after_redir", 32'(out_valid), 32'd0);
        pops1.delete(); gnt_log.delete(); cap = 1'b1; mem_en = 1'b1;
        tick(12);
        cap = 1'b0;
        chk("redir_addr", at(gnt_log, 0), 32'h0000_1000);
        chk("redir_first_pc", at(pops1, 0), 32'h0000_1000);
        chk("redir_second_pc", at(pops1, 1), 32'h0000_1004);

        // Halt with exactly one request outstanding
        imem_gnt = 1'b0;
        tick(6);
        chk("req_hold", 32'(imem_req), 32'd1);
        hold_addr = imem_addr;
        tick(2);
        chk("req_stable", 32'(imem_req), 32'd1);
        chk("addr_stable", imem_addr, hold_addr);
        mem_en = 1'b0; imem_gnt = 1'b1;
        tick(1);
        imem_gnt = 1'b0; halt = 1'b1;
        tick(1);
        chk("state_drain", 32'(dut.r_state), 32'(ST_DRAIN));
        chk("not_halted", 32'(halted), 32'd0);
        tick(2);
        chk("still_drain", 32'(dut.r_state), 32'(ST_DRAIN));
        mem_en = 1'b1;
        tick(1);
        chk("rvalid_cycle_halted", 32'(halted), 32'd0);
        tick(1);
        chk("halted_after_rvalid", 32'(halted), 32'd1);
        nexp = last_gnt_addr + 32'd4;
        halt = 1'b0; imem_gnt = 1'b1;
        tick(1);
        chk("resume_req", 32'(imem_req), 32'd1);
        chk("resume_addr", imem_addr, nexp);

        // Reset in the middle of a burst, coinciding with redirect and grant
        tick(5);
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_2000;
        #1;
        chk("mid_rst_req", 32'(imem_req), 32'd0);
        chk("mid_rst_addr", imem_addr, 32'd0);
        chk("mid_rst_ov", 32'(out_valid), 32'd0);
        chk("mid_rst_pc", out_pc, 32'd0);
        chk("mid_rst_instr", out_instr, 32'd0);
        chk("mid_rst_halted", 32'(halted), 32'd0);
        q_mem.delete(); exp_q.delete(); drop_n = 0;
        imem_rvalid = 1'b0; redirect_valid = 1'b0;
        tick(2);
        rst = 1'b0; cap = 1'b1; gnt_log.delete(); pops1.delete();
        tick(8);
        cap = 1'b0;
        chk("post_rst_addr", at(gnt_log, 0), 32'h0);
        chk("post_rst_pc", at(pops1, 0), 32'h0);

        halt = 1'b1;
        tick(10);
        chk("final_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
